// File: rtl/misc_named_value_burst_accum.sv
// Multi-channel burst accumulator.
// Each channel sums (in_a + in_b) over BURST_LEN accepted beats with
// saturation and a sticky overflow flag. The result is held in DONE and
// handed off over a valid/ready handshake. Two constant named values are
// driven alongside.
module misc_named_value_burst_accum #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int SUM_W     = 16,
    parameter int BURST_LEN = 4,
    parameter int PARAM_VAL = 10,
    parameter int CONST_VAL = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CH*DATA_W-1:0]         in_a,
    input  logic [NUM_CH*DATA_W-1:0]         in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_CH*SUM_W-1:0]          out_sum,
    output logic [NUM_CH-1:0]                out_overflow,
    output logic [$clog2(BURST_LEN+1)-1:0]   out_count,
    output logic [1:0]                       out_state,
    output logic [DATA_W-1:0]                out_param_val,
    output logic [DATA_W-1:0]                out_const_var_val
);

    localparam int CW = $clog2(BURST_LEN+1);
    // Full-precision width: accumulator plus two operands can never wrap here.
    localparam int FW = SUM_W + 2;
    localparam logic [FW-1:0] MAXV    = {2'b00, {SUM_W{1'b1}}};
    localparam logic [CW-1:0] LAST_M1 = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                           r_state, w_state_nxt;
    logic [NUM_CH-1:0][SUM_W-1:0]     r_acc, w_acc_nxt, w_add_acc;
    logic [NUM_CH-1:0]                r_ovf, w_ovf_nxt, w_add_ovf;
    logic [CW-1:0]                    r_cnt, w_cnt_nxt;
    logic [NUM_CH-1:0][FW-1:0]        w_full;

    // One beat: accumulator plus both operands, evaluated at full precision.
    task automatic beat_sum(
        input  logic [DATA_W-1:0] a,
        input  logic [DATA_W-1:0] b,
        input  logic [SUM_W-1:0]  acc,
        output logic [FW-1:0]     s
    );
        logic [FW-1:0] t;
        t = FW'(a) + FW'(b);
        s = t + FW'(acc);
    endtask

    // Per-channel saturating add; a beat taken in IDLE starts from zero.
    always_comb begin
        w_full    = '0;
        w_add_acc = '0;
        w_add_ovf = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            beat_sum(in_a[k*DATA_W +: DATA_W], in_b[k*DATA_W +: DATA_W],
                     (r_state == ST_ACCUM) ? r_acc[k] : '0, w_full[k]);
            if (w_full[k] > MAXV) begin
                w_add_acc[k] = {SUM_W{1'b1}};
                w_add_ovf[k] = 1'b1;
            end else begin
                w_add_acc[k] = w_full[k][SUM_W-1:0];
                w_add_ovf[k] = (r_state == ST_ACCUM) & r_ovf[k];
            end
        end
    end

    // Next state and next accumulator/count/overflow; clear overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
            w_ovf_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_acc_nxt   = w_add_acc;
                        w_ovf_nxt   = w_add_ovf;
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = (BURST_LEN == 1) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        w_acc_nxt = w_add_acc;
                        w_ovf_nxt = w_add_ovf;
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (r_cnt == LAST_M1)
                            w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result and count stay frozen until the consumer takes them.
                    if (out_ready) begin
                        w_state_nxt = ST_IDLE;
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and datapath registers; reset drops any partial burst at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign in_ready          = (r_state != ST_DONE) & ~clear;
    assign out_valid         = (r_state == ST_DONE);
    assign out_sum           = r_acc;
    assign out_overflow      = r_ovf;
    assign out_count         = r_cnt;
    assign out_state         = r_state;
    assign out_param_val     = DATA_W'(PARAM_VAL);
    assign out_const_var_val = DATA_W'(CONST_VAL);

endmodule
